// File: rtl/rgb_led_arbiter_if.sv
// Bus bundle between the LED requesters and the arbiter.
// The requester side drives REQ/CFGx. The arbiter side drives the grant and the LED parameters.
interface rgb_led_arbiter_if;
    logic [3:0]  REQ;
    logic [15:0] CFG0;
    logic [15:0] CFG1;
    logic [15:0] CFG2;
    logic [15:0] CFG3;
    logic [3:0]  GNT;
    logic [3:0]  RGBCOLOR;
    logic [3:0]  BRIGHTNESS;
    logic [3:0]  BREATHRAMP;
    logic [3:0]  BLINKRATE;
    logic        PARAMSOK;
    logic        BUSY;

    modport master (
        output REQ, CFG0, CFG1, CFG2, CFG3,
        input  GNT, RGBCOLOR, BRIGHTNESS, BREATHRAMP, BLINKRATE, PARAMSOK, BUSY
    );

    modport slave (
        input  REQ, CFG0, CFG1, CFG2, CFG3,
        output GNT, RGBCOLOR, BRIGHTNESS, BREATHRAMP, BLINKRATE, PARAMSOK, BUSY
    );
endinterface

// File: rtl/rgb_led_arbiter.sv
// Fixed-priority owner arbiter for a shared RGB LED.
// An owner keeps the LED for at least HOLD_CYCLES before it can be preempted, reconfigured or released.
module rgb_led_arbiter #(
    parameter int                HOLD_W      = 24,
    parameter logic [HOLD_W-1:0] HOLD_CYCLES = 24'd1350000
) (
    input  logic                CLK,
    input  logic                RST_N,
    rgb_led_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RELEASE} state_e;

    state_e            state_q;
    logic [1:0]        idx_q;
    logic [1:0]        owner_q;
    logic [3:0]        gnt_q;
    logic [15:0]       par_q;
    logic              ok_q;
    logic [HOLD_W-1:0] cnt_q;

    logic [15:0] cfg [4];
    logic [1:0]  win;
    logic        any_req;
    logic        owner_req;
    logic [15:0] owner_cfg;

    assign cfg[0] = bus.CFG0;
    assign cfg[1] = bus.CFG1;
    assign cfg[2] = bus.CFG2;
    assign cfg[3] = bus.CFG3;

    assign any_req   = |bus.REQ;
    assign owner_req = bus.REQ[owner_q];
    assign owner_cfg = cfg[owner_q];

    // Highest asserted index wins; value is only used when any_req is set.
    always_comb begin
        win = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (bus.REQ[i]) win = 2'(i);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            owner_q <= 2'd0;
            gnt_q   <= 4'd0;
            par_q   <= 16'd0;
            ok_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ok_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        idx_q   <= win;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    par_q   <= cfg[idx_q];
                    owner_q <= idx_q;
                    gnt_q   <= 4'b0001 << idx_q;
                    ok_q    <= 1'b1;
                    cnt_q   <= HOLD_CYCLES - 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    // Inputs are ignored entirely until the minimum hold time has elapsed.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (any_req && (win != owner_q)) begin
                        idx_q   <= win;
                        state_q <= LOAD;
                    end else if (owner_req && (owner_cfg != par_q)) begin
                        idx_q   <= owner_q;
                        state_q <= LOAD;
                    end else if (!any_req) begin
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    par_q   <= 16'd0;
                    gnt_q   <= 4'd0;
                    ok_q    <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.GNT        = gnt_q;
    assign bus.RGBCOLOR   = par_q[15:12];
    assign bus.BRIGHTNESS = par_q[11:8];
    assign bus.BREATHRAMP = par_q[7:4];
    assign bus.BLINKRATE  = par_q[3:0];
    assign bus.PARAMSOK   = ok_q;
    assign bus.BUSY       = (state_q != IDLE);
endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Scoreboard bench for rgb_led_arbiter: a decision-time reference model queues every expected
// parameter update, and a monitor matches them against PARAMSOK pulses and per-cycle outputs.
module tb_rgb_led_arbiter;
    localparam int HOLD = 8;

    logic clk;
    logic rst_n;
    rgb_led_arbiter_if bus();

    rgb_led_arbiter #(.HOLD_W(24), .HOLD_CYCLES(24'd8)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [3:0]  gnt;
        logic [15:0] par;
    } txn_t;

    txn_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   pulse_cnt = 0;

    // Reference model state: who owns the LED, what it shows, and when it may next decide.
    int          m_owner   = -1;
    logic [15:0] m_par     = 16'd0;
    bit          m_pending = 1'b0;
    int          m_pend_idx = -1;
    int          m_eval_at = 0;
    logic [3:0]  m_gnt     = 4'd0;
    logic        m_busy    = 1'b0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    endtask

    function automatic logic [15:0] cfg_of(input int k);
        case (k)
            0:       return bus.CFG0;
            1:       return bus.CFG1;
            2:       return bus.CFG2;
            default: return bus.CFG3;
        endcase
    endfunction

    function automatic logic [15:0] out_par();
        return {bus.RGBCOLOR, bus.BRIGHTNESS, bus.BREATHRAMP, bus.BLINKRATE};
    endfunction

    // Model: a decision taken at edge n takes effect at edge n+1; a grant blocks decisions until n+HOLD.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_owner = -1; m_par = 16'd0; m_pending = 1'b0; m_eval_at = 0;
            q.delete();
        end else begin
            cyc++;
            if (m_pending) begin
                txn_t t;
                m_pending = 1'b0;
                if (m_pend_idx < 0) begin
                    m_owner = -1; m_par = 16'd0; m_eval_at = cyc + 1;
                end else begin
                    m_owner = m_pend_idx; m_par = cfg_of(m_pend_idx); m_eval_at = cyc + HOLD;
                end
                t.cyc = cyc;
                t.gnt = (m_owner < 0) ? 4'd0 : 4'(1 << m_owner);
                t.par = m_par;
                q.push_back(t);
            end else if (cyc >= m_eval_at) begin
                int w;
                w = -1;
                for (int i = 0; i < 4; i++) if (bus.REQ[i]) w = i;
                if (m_owner < 0) begin
                    if (w >= 0) begin m_pending = 1'b1; m_pend_idx = w; end
                end else if (w >= 0 && w != m_owner) begin
                    m_pending = 1'b1; m_pend_idx = w;
                end else if (bus.REQ[m_owner] && cfg_of(m_owner) != m_par) begin
                    m_pending = 1'b1; m_pend_idx = m_owner;
                end else if (bus.REQ == 4'd0) begin
                    m_pending = 1'b1; m_pend_idx = -1;
                end
            end
        end
        m_gnt  = (m_owner < 0) ? 4'd0 : 4'(1 << m_owner);
        m_busy = (m_owner >= 0) || m_pending;
    end

    // Monitor: consumes queued updates when PARAMSOK is (or should be) presented.
    initial forever begin
        bit exp_pulse;
        txn_t t;
        @(negedge clk);
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                check("pulse_missed", 0, 1);
                void'(q.pop_front());
            end
            exp_pulse = (q.size() > 0) && (q[0].cyc == cyc);
            check("paramsok", bus.PARAMSOK, exp_pulse);
            if (bus.PARAMSOK) pulse_cnt++;
            if (exp_pulse) begin
                t = q.pop_front();
                check("txn_gnt", bus.GNT, t.gnt);
                check("txn_par", out_par(), t.par);
            end
            check("gnt", bus.GNT, m_gnt);
            check("busy", bus.BUSY, m_busy);
            check("params", out_par(), m_par);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] pick_cfg();
        case ($urandom_range(0, 2))
            0:       return 16'h1111;
            1:       return 16'h2222;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int p0;
        rst_n = 1'b0;
        bus.REQ = 4'd0;
        bus.CFG0 = 16'h0000; bus.CFG1 = 16'hC0DE; bus.CFG2 = 16'h5D19; bus.CFG3 = 16'h7C4B;
        cycles(3);
        #1;
        check("rst_gnt", bus.GNT, 0);
        check("rst_par", out_par(), 0);
        check("rst_paramsok", bus.PARAMSOK, 0);
        check("rst_busy", bus.BUSY, 0);
        @(negedge clk); #2 rst_n = 1'b1;

        // Single request, dropped during hold.
        @(negedge clk);
        bus.CFG0 = 16'h3A52; bus.REQ = 4'b0001;
        cycles(4); bus.REQ = 4'b0000;
        cycles(16);

        // Higher request arrives during hold: no preemption until expiry.
        bus.REQ = 4'b0001; cycles(2);
        bus.REQ = 4'b1001; cycles(14);
        bus.REQ = 4'b0000; cycles(20);

        // Simultaneous requests.
        bus.REQ = 4'b0110; cycles(14);
        bus.REQ = 4'b0010; cycles(14);
        bus.REQ = 4'b0000; cycles(20);

        // Owner reconfigures during hold.
        bus.CFG0 = 16'h1111; bus.REQ = 4'b0001; cycles(3);
        bus.CFG0 = 16'h2222; cycles(20);
        bus.REQ = 4'b0000; cycles(20);

        // Steady owner: exactly one update.
        p0 = pulse_cnt;
        bus.REQ = 4'b0001; cycles(40);
        #1 check("steady_pulses", pulse_cnt - p0, 1);
        check("steady_gnt", bus.GNT, 4'b0001);
        check("steady_busy", bus.BUSY, 1);

        // Reset in the middle of a hold.
        @(negedge clk);
        bus.REQ = 4'b0000; cycles(20);
        bus.REQ = 4'b0001; cycles(5);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_gnt", bus.GNT, 0);
        check("midrst_par", out_par(), 0);
        check("midrst_paramsok", bus.PARAMSOK, 0);
        check("midrst_busy", bus.BUSY, 0);
        @(negedge clk);
        #2 bus.REQ = 4'b0010; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("postrst_gnt", bus.GNT, 4'b0010);
        check("postrst_paramsok", bus.PARAMSOK, 1);

        // Randomized traffic.
        @(negedge clk);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0)
                bus.REQ = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 14) == 0) begin
                case ($urandom_range(0, 3))
                    0:       bus.CFG0 = pick_cfg();
                    1:       bus.CFG1 = pick_cfg();
                    2:       bus.CFG2 = pick_cfg();
                    default: bus.CFG3 = pick_cfg();
                endcase
            end
            @(negedge clk);
        end

        bus.REQ = 4'd0;
        cycles(30);
        #1 check("queue_empty", q.size(), 0);
        check("final_busy", bus.BUSY, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
